// File: rtl/cordic_pol_to_rect.sv
// Serial rotation-mode CORDIC: polar (mag, ph) to rectangular (xout, yout).
// One iteration per clock; start/ready handshake; inverse of cordicMagPh.
module cordic_pol_to_rect #(
    parameter string       CORDIC_TYPE = "SERIAL",
    parameter int unsigned N           = 16,
    parameter int unsigned XY_WIDTH    = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st,
    input  logic [XY_WIDTH-1:0]        mag,
    input  logic signed [XY_WIDTH+1:0] ph,
    output logic                       rdy,
    output logic signed [XY_WIDTH:0]   xout,
    output logic signed [XY_WIDTH:0]   yout
);

    localparam int unsigned G    = $clog2(N) + 2;
    localparam int unsigned PHW  = XY_WIDTH + 2;
    localparam int unsigned OW   = XY_WIDTH + 1;
    // One bit above mag+sign absorbs the CORDIC gain (~1.647) at full-scale mag.
    localparam int unsigned XW   = XY_WIDTH + 2 + G;
    localparam int unsigned ZW   = XY_WIDTH + 2 + G;
    localparam int unsigned AF   = XY_WIDTH + 1 + G;
    localparam int unsigned KW   = XY_WIDTH + G + 1;
    localparam int unsigned PW   = XW + KW;
    localparam int unsigned SH   = XY_WIDTH + 2 * G;
    localparam int unsigned CW   = $clog2(N);
    localparam int unsigned MAXO = 2 ** XY_WIDTH - 1;

    if (CORDIC_TYPE != "SERIAL") begin : g_bad_type
        $error("cordic_pol_to_rect: only CORDIC_TYPE \"SERIAL\" is supported");
    end
    if (XY_WIDTH < 8 || XY_WIDTH > 24) begin : g_bad_width
        $error("cordic_pol_to_rect: XY_WIDTH must be in 8..24");
    end
    if (N < 8 || N > XY_WIDTH + 4) begin : g_bad_n
        $error("cordic_pol_to_rect: N must be in 8..XY_WIDTH+4");
    end

    // atan(2^-idx) in z units (pi = 2^AF), via integer series at pi*2^100 scale.
    function automatic logic [ZW-1:0] atan_entry(input int unsigned idx);
        logic [159:0] s_pi, acc, term, num;
        int unsigned  sh;
        s_pi = 160'h3243F6A8885A308D313198A2E0;
        acc  = '0;
        if (idx == 0) begin
            acc = s_pi >> 2;
        end else begin
            for (int k = 0; k < 64; k++) begin
                sh = idx * (2 * k + 1);
                if (sh < 100) begin
                    term = (160'd1 << (100 - sh)) / 160'(2 * k + 1);
                    if (k % 2 == 0) acc = acc + term;
                    else            acc = acc - term;
                end
            end
        end
        num = (acc << AF) + (s_pi >> 1);
        return ZW'(num / s_pi);
    endfunction

    function automatic logic [N*ZW-1:0] atan_table();
        logic [N*ZW-1:0] tab;
        tab = '0;
        for (int unsigned i = 0; i < N; i++) begin
            tab[i*ZW +: ZW] = atan_entry(i);
        end
        return tab;
    endfunction

    function automatic logic [KW-1:0] kinv_calc();
        logic [95:0] num;
        num = (96'd6072529350 << (XY_WIDTH + G)) + 96'd5000000000;
        return KW'(num / 96'd10000000000);
    endfunction

    localparam logic [N*ZW-1:0]      ATAN_TAB = atan_table();
    localparam logic signed [PW-1:0] KINV     = PW'(kinv_calc());
    localparam logic signed [PHW-1:0] Q_PH    = PHW'(2 ** XY_WIDTH);

    // Round half away from zero, drop all fraction bits, saturate.
    function automatic logic signed [OW-1:0] round_sat(input logic signed [PW-1:0] p);
        logic [PW-1:0] a, r;
        a = p[PW-1] ? $unsigned(-p) : $unsigned(p);
        r = (a + (PW'(1) << (SH - 1))) >> SH;
        if (r > PW'(MAXO)) r = PW'(MAXO);
        return p[PW-1] ? $signed(-OW'(r)) : $signed(OW'(r));
    endfunction

    typedef enum logic [1:0] {IDLE, ROT, SCALE} state_t;

    state_t                  state;
    logic signed [XW-1:0]    x_r, y_r;
    logic signed [ZW-1:0]    z_r;
    logic [CW-1:0]           cnt;

    logic signed [XW-1:0]    mag_ext, x0, y0, x_sh, y_sh;
    logic signed [PHW-1:0]   ph_adj;
    logic signed [ZW-1:0]    z0, atan_cur;
    logic signed [PW-1:0]    prod_x, prod_y;

    // Quadrant pre-rotation so the iterations only cover [-pi/2, pi/2).
    always_comb begin
        mag_ext = {2'b00, mag, {G{1'b0}}};
        x0      = mag_ext;
        y0      = '0;
        ph_adj  = ph;
        if (ph >= Q_PH) begin
            x0     = '0;
            y0     = mag_ext;
            ph_adj = ph - Q_PH;
        end else if (ph < -Q_PH) begin
            x0     = '0;
            y0     = -mag_ext;
            ph_adj = ph + Q_PH;
        end
        z0 = {ph_adj, {G{1'b0}}};
    end

    assign x_sh     = x_r >>> cnt;
    assign y_sh     = y_r >>> cnt;
    assign atan_cur = ATAN_TAB[32'(cnt) * ZW +: ZW];
    assign prod_x   = PW'(x_r) * KINV;
    assign prod_y   = PW'(y_r) * KINV;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rdy   <= 1'b1;
            xout  <= '0;
            yout  <= '0;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (st) begin
                        x_r   <= x0;
                        y_r   <= y0;
                        z_r   <= z0;
                        cnt   <= '0;
                        rdy   <= 1'b0;
                        state <= ROT;
                    end
                end
                ROT: begin
                    if (!z_r[ZW-1]) begin
                        x_r <= x_r - y_sh;
                        y_r <= y_r + x_sh;
                        z_r <= z_r - atan_cur;
                    end else begin
                        x_r <= x_r + y_sh;
                        y_r <= y_r - x_sh;
                        z_r <= z_r + atan_cur;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) state <= SCALE;
                end
                SCALE: begin
                    xout  <= round_sat(prod_x);
                    yout  <= round_sat(prod_y);
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_pol_to_rect.sv
// Directed bench for cordic_pol_to_rect (XY_WIDTH=12, N=16).
// Expected values are hand-computed mag*cos/sin with a +-2 LSB window.
module tb_cordic_pol_to_rect;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               st = 1'b0;
    logic [11:0]        mag = '0;
    logic signed [13:0] ph = '0;
    logic               rdy;
    logic signed [12:0] xout, yout;

    int n_pass   = 0;
    int n_checks = 0;
    int cycle_no = 0;

    cordic_pol_to_rect #(.CORDIC_TYPE("SERIAL"), .N(16), .XY_WIDTH(12)) dut (
        .clk   (clk),
        .reset (reset),
        .st    (st),
        .mag   (mag),
        .ph    (ph),
        .rdy   (rdy),
        .xout  (xout),
        .yout  (yout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic check(input string tag, input int got, input int exp, input int tol);
        n_checks++;
        if (got >= exp - tol && got <= exp + tol) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (+-%0d)", tag, got, exp, tol);
        end
    endtask

    task automatic wait_rdy();
        int guard = 0;
        while (!rdy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    // One conversion: start, count busy cycles, check latency and result.
    task automatic convert(input string tag, input int m, input int p,
                           input int ex, input int ey, input int tol);
        int cyc = 0;
        wait_rdy();
        mag = 12'(m);
        ph  = 14'(p);
        st  = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        while (!rdy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, 17, 0);
        check({tag, "_x"}, int'(xout), ex, tol);
        check({tag, "_y"}, int'(yout), ey, tol);
    endtask

    int rises [5];
    int n_rise;
    int cyc;
    logic prev;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", int'(rdy), 1, 0);
        check("rst_x", int'(xout), 0, 0);
        check("rst_y", int'(yout), 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_rdy", int'(rdy), 1, 0);
        check("rel_x", int'(xout), 0, 0);
        check("rel_y", int'(yout), 0, 0);

        convert("ph0",     2047,     0,  2047,     0, 2);
        convert("ph90",    2047,  4096,     0,  2047, 2);
        convert("phm180",  2047, -8192, -2047,     0, 2);
        convert("ph45",    2047,  2048,  1447,  1447, 2);
        convert("mag0",       0,  1234,     0,     0, 0);
        convert("ph30",    1000,  1365,   866,   500, 2);
        convert("fs0",     4095,     0,  4095,     0, 2);
        convert("fsm90",   4095, -4096,     0, -4095, 2);
        convert("ph135",   2047,  6144, -1447,  1447, 2);
        convert("phm135",  2047, -6144, -1447, -1447, 2);
        convert("phmax",   2047,  8191, -2047,     1, 2);

        // Busy st pulse is ignored; outputs hold previous result while busy.
        mag = 12'd2047; ph = 14'sd0; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        cyc = 0;
        repeat (4) begin @(posedge clk); #1; cyc++; end
        check("busy_rdy", int'(rdy), 0, 0);
        check("hold_x", int'(xout), -2047, 2);
        check("hold_y", int'(yout), 1, 2);
        mag = 12'd1000; ph = 14'sd4096; st = 1'b1;
        @(posedge clk); #1;
        cyc++;
        st = 1'b0;
        while (!rdy && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("pulse_lat", cyc, 17, 0);
        check("pulse_x", int'(xout), 2047, 2);
        check("pulse_y", int'(yout), 0, 2);
        repeat (3) @(posedge clk);
        #1;
        check("noqueue_rdy", int'(rdy), 1, 0);

        // st held high: results every 18 cycles.
        mag = 12'd1000; ph = 14'sd1365; st = 1'b1;
        n_rise = 0;
        prev = rdy;
        for (int i = 0; i < 5; i++) rises[i] = 0;
        for (int c = 0; c < 200 && n_rise < 5; c++) begin
            @(posedge clk); #1;
            if (rdy && !prev) begin
                rises[n_rise] = cycle_no;
                n_rise++;
            end
            prev = rdy;
        end
        st = 1'b0;
        check("b2b_count", n_rise, 5, 0);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("b2b_gap%0d", i), rises[i] - rises[i-1], 18, 0);
        end
        check("b2b_x", int'(xout), 866, 2);
        check("b2b_y", int'(yout), 500, 2);

        // Asynchronous reset mid-rotation clears outputs without a clock edge.
        wait_rdy();
        mag = 12'd2047; ph = 14'sd2048; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_rdy", int'(rdy), 1, 0);
        check("arst_x", int'(xout), 0, 0);
        check("arst_y", int'(yout), 0, 0);
        @(negedge clk);
        reset = 1'b1;
        convert("post_rst", 2047, -2048, 1447, -1447, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
